// File: rtl/alu_bus_master_if.sv
// Request/response and datapath bus bundle for alu_bus_master.
// The master modport is the sequencer; the slave modport is the host plus datapath side.
interface alu_bus_master_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_hi;
  logic [DATA_W-1:0] rsp_lo;
  logic              rsp_err;

  logic [2:0]        INS;
  logic [DATA_W-1:0] inBUS;
  logic              LDDR, LDMQ, LDAcc;
  logic              STDR, STMQ, STAcc;
  logic [DATA_W-1:0] outBUS;
  logic              RDY;

  modport master (
    input  req_valid, req_op, req_a, req_b, rsp_ready, outBUS, RDY,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
           INS, inBUS, LDDR, LDMQ, LDAcc, STDR, STMQ, STAcc
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, rsp_ready, outBUS, RDY,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
           INS, inBUS, LDDR, LDMQ, LDAcc, STDR, STMQ, STAcc
  );
endinterface

// File: rtl/alu_bus_master.sv
// Host-side sequencer for the Acc/MQ/DR shift/add ALU: load operands, issue, await RDY, read back.
// Define ALU_BUS_MASTER_READBACK_EN to verify DR over outBUS before issuing the opcode.
module alu_bus_master #(
  parameter int         DATA_W   = 8,
  parameter int         TIMEOUT  = 63,
  parameter logic [2:0] IDLE_INS = 3'b000
) (
  input logic             clock,
  input logic             reset,
  alu_bus_master_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE,
    LD_DR,
    LD_MQ,
`ifdef ALU_BUS_MASTER_READBACK_EN
    VFY_DR,
`endif
    CLR_ACC,
    ISSUE,
    WAIT,
    RD_ACC,
    RD_MQ,
    RESP
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] rsp_hi_q, rsp_lo_q;
  logic              rsp_err_q;

  // RDY is only trusted once the datapath has had a full cycle to drop a stale RDY.
  logic rdy_ok, timed_out;
  assign rdy_ok    = bus.RDY && (wait_cnt != '0);
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

  assign bus.rsp_hi  = rsp_hi_q;
  assign bus.rsp_lo  = rsp_lo_q;
  assign bus.rsp_err = rsp_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    next_state    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.INS       = IDLE_INS;
    bus.inBUS     = '0;
    bus.LDDR      = 1'b0;
    bus.LDMQ      = 1'b0;
    bus.LDAcc     = 1'b0;
    bus.STDR      = 1'b0;
    bus.STMQ      = 1'b0;
    bus.STAcc     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = LD_DR;
      end
      LD_DR: begin
        bus.inBUS  = a_q;
        bus.LDDR   = 1'b1;
        next_state = LD_MQ;
      end
      LD_MQ: begin
        bus.inBUS  = b_q;
        bus.LDMQ   = 1'b1;
`ifdef ALU_BUS_MASTER_READBACK_EN
        next_state = VFY_DR;
`else
        next_state = CLR_ACC;
`endif
      end
`ifdef ALU_BUS_MASTER_READBACK_EN
      VFY_DR: begin
        bus.STDR   = 1'b1;
        next_state = (bus.outBUS == a_q) ? CLR_ACC : RESP;
      end
`endif
      CLR_ACC: begin
        bus.LDAcc  = 1'b1;
        next_state = ISSUE;
      end
      ISSUE: begin
        bus.INS    = op_q;
        next_state = WAIT;
      end
      WAIT: begin
        bus.INS = op_q;
        if (rdy_ok)         next_state = RD_ACC;
        else if (timed_out) next_state = RESP;
      end
      RD_ACC: begin
        bus.STAcc  = 1'b1;
        next_state = RD_MQ;
      end
      RD_MQ: begin
        bus.STMQ   = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
          end
        end
`ifdef ALU_BUS_MASTER_READBACK_EN
        VFY_DR: begin
          if (bus.outBUS != a_q) begin
            rsp_err_q <= 1'b1;
            rsp_hi_q  <= '0;
            rsp_lo_q  <= '0;
          end
        end
`endif
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (!timed_out) wait_cnt <= wait_cnt + CNT_W'(1);
          if (!rdy_ok && timed_out) begin
            rsp_err_q <= 1'b1;
            rsp_hi_q  <= '0;
            rsp_lo_q  <= '0;
          end
        end
        RD_ACC: rsp_hi_q <= bus.outBUS;
        RD_MQ: begin
          rsp_lo_q  <= bus.outBUS;
          rsp_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bus_master.sv
// Self-checking bench for alu_bus_master: behavioural Acc/MQ/DR datapath model plus response scoreboard.
// Build with ALU_BUS_MASTER_READBACK_EN defined to exercise the DR readback path.
module tb_alu_bus_master;

  localparam int         DATA_W   = 8;
  localparam int         TIMEOUT  = 63;
  localparam logic [2:0] IDLE_INS = 3'b000;
`ifdef ALU_BUS_MASTER_READBACK_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_bus_master_if #(.DATA_W(DATA_W)) bus ();

  alu_bus_master #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .IDLE_INS(IDLE_INS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- datapath model ----------------
  logic [7:0] dr = '0, mq = '0, acc = '0;
  int         ins_cycles = 0;
  bit         done       = 1'b0;
  bit         corrupt    = 1'b0;
  int         rdy_from   = 1000;
  int         strobe_log[$];
  bit         ins_seen   = 1'b0;
  int         inv_bad    = 0;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 3'b101) return 16'(a) * 16'(b);
    return {a & b, 8'(a + b)};
  endfunction

  always_comb begin
    bus.outBUS = (bus.STDR  ? (corrupt ? 8'hFF : dr) : 8'h00)
               | (bus.STMQ  ? mq  : 8'h00)
               | (bus.STAcc ? acc : 8'h00);
    bus.RDY    = (bus.INS != IDLE_INS) && (ins_cycles >= rdy_from);
  end

  always @(posedge clock) begin
    int ld, st;
    ld = int'(bus.LDDR) + int'(bus.LDMQ) + int'(bus.LDAcc);
    st = int'(bus.STDR) + int'(bus.STMQ) + int'(bus.STAcc);
    if (ld > 1 || st > 1 || (ld > 0 && st > 0) || (ld == 0 && bus.inBUS != 8'h00))
      inv_bad <= inv_bad + 1;
    if (bus.LDDR)  begin dr  <= bus.inBUS; strobe_log.push_back(1); end
    if (bus.LDMQ)  begin mq  <= bus.inBUS; strobe_log.push_back(2); end
    if (bus.LDAcc) begin acc <= bus.inBUS; strobe_log.push_back(3); end
    if (bus.STAcc) strobe_log.push_back(4);
    if (bus.STMQ)  strobe_log.push_back(5);
    if (bus.STDR)  strobe_log.push_back(6);
    if (bus.RDY && !done) begin
      {acc, mq} <= alu_f(bus.INS, dr, mq);
      done      <= 1'b1;
    end
    if (bus.INS != IDLE_INS) begin
      ins_cycles <= ins_cycles + 1;
      ins_seen   <= 1'b1;
    end else begin
      ins_cycles <= 0;
      done       <= 1'b0;
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] log_word();
    logic [31:0] w = '0;
    foreach (strobe_log[i]) w = (w << 4) | 32'(strobe_log[i]);
    return w;
  endfunction

  // Drive one request; lat is the handshake-to-rsp_valid cycle count expected for it.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] res, input logic err, input int lat,
                      input bit keep_valid, output int c);
    int n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_before_send", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    strobe_log.delete();
    ins_seen = 1'b0;
    c = cyc;
    sb.push_back('{res[15:8], res[7:0], err, c + lat});
    @(negedge clock);
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   n = 0;
    exp_t e;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    e = sb.pop_front();
    if (!bus.rsp_valid) begin
      check("rsp_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
    check("rsp_hi", 32'(bus.rsp_hi), 32'(e.hi));
    check("rsp_lo", 32'(bus.rsp_lo), 32'(e.lo));
    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_hi", 32'(bus.rsp_hi), 32'(e.hi));
      check("hold_lo", 32'(bus.rsp_lo), 32'(e.lo));
      check("hold_err", 32'(bus.rsp_err), 32'(e.err));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_strobes"}, 32'({bus.LDDR, bus.LDMQ, bus.LDAcc, bus.STDR, bus.STMQ, bus.STAcc}), 32'd0);
    check({tag, "_inBUS"}, 32'(bus.inBUS), 32'd0);
    check({tag, "_INS"}, 32'(bus.INS), 32'(IDLE_INS));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, h;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check_quiet("reset");
    check("reset_rsp_hi", 32'(bus.rsp_hi), 32'd0);
    check("reset_rsp_lo", 32'(bus.rsp_lo), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;

    // Basic multiply, RDY at wait_cnt=8
    rdy_from = 9;
    send(3'b101, 8'h05, 8'h07, 16'h0023, 1'b0, 8 + 8 + X, 1'b0, c);
    collect(0);
    check("basic_strobe_order", log_word(), (X == 1) ? 32'h126345 : 32'h12345);

    // Further patterns at different RDY delays
    rdy_from = 2;
    send(3'b011, 8'hC8, 8'h64, alu_f(3'b011, 8'hC8, 8'h64), 1'b0, 8 + 1 + X, 1'b0, c);
    collect(0);
    rdy_from = 4;
    send(3'b101, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 8 + 3 + X, 1'b0, c);
    collect(0);

    // Timeout: RDY never rises
    rdy_from = 1000;
    send(3'b101, 8'h11, 8'h22, 16'h0000, 1'b1, 5 + TIMEOUT + 1 + X, 1'b0, c);
    collect(0);
    check("timeout_strobe_order", log_word(), (X == 1) ? 32'h1263 : 32'h123);

    // RDY on the final WAIT cycle beats the timeout
    rdy_from = TIMEOUT + 1;
    send(3'b101, 8'h03, 8'h04, 16'h000C, 1'b0, 8 + TIMEOUT + X, 1'b0, c);
    collect(0);

    // RDY early: ISSUE and wait_cnt=0 must be ignored
    rdy_from = 0;
    send(3'b001, 8'h0A, 8'h14, alu_f(3'b001, 8'h0A, 8'h14), 1'b0, 8 + 1 + X, 1'b0, c);
    collect(0);

    // Backpressure with req_valid held high, second request queued behind
    rdy_from = 3;
    send(3'b101, 8'h09, 8'h0B, 16'h0063, 1'b0, 8 + 2 + X, 1'b1, c);
    bus.req_op = 3'b010;
    bus.req_a  = 8'h3C;
    bus.req_b  = 8'h5A;
    collect(10);
    h  = cyc - 1;
    c2 = cyc;
    check("second_req_ready", 32'(bus.req_ready), 32'd1);
    sb.push_back('{8'h18, 8'h96, 1'b0, h + 1 + 8 + 2 + X});
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("second_req_cycle", 32'(c2), 32'(h + 1));
    collect(0);

    // Reset while waiting at wait_cnt=3
    rdy_from = 1000;
    send(3'b101, 8'h21, 8'h02, 16'h0000, 1'b0, 0, 1'b0, c);
    while (cyc < c + 8 + X) @(negedge clock);
    reset = 1'b1;
    #1;
    check_quiet("wait_reset");
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b0;
    rdy_from = 2;
    send(3'b101, 8'h06, 8'h07, 16'h002A, 1'b0, 8 + 1 + X, 1'b0, c);
    collect(0);

`ifdef ALU_BUS_MASTER_READBACK_EN
    // DR readback corrupted: error response, no issue, no Acc/MQ reads
    corrupt = 1'b1;
    send(3'b101, 8'h05, 8'h07, 16'h0000, 1'b1, 4, 1'b0, c);
    collect(0);
    corrupt = 1'b0;
    check("readback_strobe_order", log_word(), 32'h126);
    check("readback_ins_idle", 32'(ins_seen), 32'd0);
`endif

    check("bus_invariants", 32'(inv_bad), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_bus_master.md
Name: alu_bus_master

Overview:
- Host-side sequencer for the 8-bit shift/add ALU datapath with Acc/MQ/DR registers and a shared bus.
- Accepts an operation request (opcode plus two operands) on a valid/ready port.
- Drives the datapath's INS, inBUS and LDxx/STxx strobes to load the operands and issue the opcode. Waits for RDY, then reads Acc and MQ back over outBUS.
- Returns the 2×DATA_W result on a valid/ready response port, with a timeout error path.

Parameters:
- DATA_W, 8: datapath/bus width.
- TIMEOUT, 63: maximum wait_cnt value before the WAIT state gives up.
- IDLE_INS, 3'b000: INS value driven outside ISSUE/WAIT.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  opcode to issue on INS.
- req_a  in  DATA_W  operand loaded into DR.
- req_b  in  DATA_W  operand loaded into MQ.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_hi  out  DATA_W  Acc readback.
- rsp_lo  out  DATA_W  MQ readback.
- rsp_err  out  1  timeout or readback error.
- INS  out  3  datapath instruction.
- inBUS  out  DATA_W  write bus to the datapath.
- LDDR, LDMQ, LDAcc  out  1 each  load strobes.
- STDR, STMQ, STAcc  out  1 each  store (read) strobes.
- outBUS  in  DATA_W  read bus from the datapath (OR of the enabled registers).
- RDY  in  1  datapath done.

Behaviour:
- Moore FSM. All datapath strobes, inBUS, INS and req_ready are decoded from the state register only.
- States: IDLE, LD_DR, LD_MQ, [VFY_DR], CLR_ACC, ISSUE, WAIT, RD_ACC, RD_MQ, RESP.
- Reset (asynchronous, any state): state=IDLE, wait_cnt=0, rsp_hi=rsp_lo=0, rsp_err=0, op/a/b capture registers=0. Consequently req_ready=1, rsp_valid=0, all LD/ST strobes=0, inBUS=0, INS=IDLE_INS.
- IDLE: req_ready=1. When req_valid=1, capture req_op/req_a/req_b and go to LD_DR. req_* is ignored in every other state.
- LD_DR: inBUS=a, LDDR=1 → LD_MQ.
- LD_MQ: inBUS=b, LDMQ=1 → VFY_DR if the feature is compiled in, else CLR_ACC.
- CLR_ACC: inBUS=0, LDAcc=1 → ISSUE.
- ISSUE: INS=op, wait_cnt←0 → WAIT.
- WAIT: INS=op held every cycle. wait_cnt increments each cycle, saturating at TIMEOUT.
  - RDY is ignored while wait_cnt==0.
  - RDY=1 with wait_cnt≥1 → RD_ACC.
  - RDY=0 with wait_cnt==TIMEOUT → RESP with rsp_err=1, rsp_hi=rsp_lo=0.
  - RDY and the timeout in the same cycle: RDY wins.
- RD_ACC: STAcc=1, rsp_hi←outBUS at the clock edge → RD_MQ.
- RD_MQ: STMQ=1, rsp_lo←outBUS, rsp_err←0 → RESP.
- RESP: rsp_valid=1. rsp_hi/lo/err are stable until the handshake. rsp_valid&&rsp_ready → IDLE; a new request may be accepted the following cycle.
- Invariants:
  - At most one LD strobe and at most one ST strobe per cycle; never an LD and an ST in the same cycle.
  - inBUS=0 whenever no LD strobe is active.
  - INS=IDLE_INS outside ISSUE/WAIT.
- Latency (feature off): handshake cycle c; LD_DR c+1; LD_MQ c+2; CLR_ACC c+3; ISSUE c+4; WAIT from c+5. If RDY is seen at WAIT cycle c+5+k (k≥1), rsp_valid rises at c+8+k.
- Reset during any state aborts the transaction with no response. The datapath registers are not cleared.

Optional Feature:
- Macro: ALU_BUS_MASTER_READBACK_EN.
- Defined: VFY_DR inserted after LD_MQ. It drives STDR=1 and compares outBUS to the captured a.
  - Equal → CLR_ACC.
  - Mismatch → RESP with rsp_err=1, rsp_hi=rsp_lo=0. No ISSUE occurs.
  - Latency grows by one cycle.
- Undefined: state absent, STDR is tied 0, LD_MQ → CLR_ACC.

Test Plan:
- Basic: req_op=3'b101, a=8'h05, b=8'h07. Datapath model raises RDY at wait_cnt=8 and returns Acc=8'h00, MQ=8'h23. Required: rsp_hi=8'h00, rsp_lo=8'h23, rsp_err=0, rsp_valid at the computed cycle, strobe order LDDR, LDMQ, LDAcc, STAcc, STMQ.
- Timeout: RDY held 0. Required: rsp_valid with rsp_err=1 and zero data exactly TIMEOUT+1 WAIT cycles after ISSUE; RDY=1 on that final cycle instead yields a normal response.
- Backpressure and ignore-while-busy: rsp_ready=0 for 10 cycles with req_valid=1 throughout. Required: rsp data stable, req_ready=0, a second request is accepted only in the cycle after the response handshake.
- Reset in WAIT: assert reset at wait_cnt=3. Required: req_ready=1, rsp_valid=0, all strobes 0, INS=IDLE_INS immediately; a fresh request then completes normally.
- RDY early: RDY=1 in the ISSUE cycle and at wait_cnt=0. Required: ignored; transition to RD_ACC at wait_cnt=1.
- Readback (macro defined): model corrupts DR to 8'hFF for a=8'h05. Required: rsp_err=1, no STAcc/STMQ, INS never leaves IDLE_INS.
